led_cmd_arbiter: RTL

LED_CMD_ARBITER -- requirements
Module: led_cmd_arbiter

---
 rtl/led_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/led_cmd_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED command arbiter.
// Combinational helpers only; no latency and no flow control live here.
package led_pkg;

    localparam int LED_IDX_W = 3;
    localparam int LED_W     = 8;
    localparam logic [LED_IDX_W-1:0] LED_CODE_CLEAR = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2,
        ACK   = 2'd3
    } led_state_e;

    typedef struct packed {
        logic [LED_IDX_W-1:0] idx;
        logic                 lit;
    } led_cmd_t;

    // The top bit can never be addressed (idx 7 maps to bit 6), so it is forced low.
    function automatic logic [LED_W-1:0] shadow_apply(input logic [LED_W-1:0] cur,
                                                       input led_cmd_t        cmd);
        logic [LED_W-1:0] img;
        img = cur;
        if (cmd.idx == LED_CODE_CLEAR) begin
            img = '0;
        end else begin
            img[cmd.idx - 3'd1] = cmd.lit;
        end
        img[LED_W-1] = 1'b0;
        return img;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or above ptr, wrapping; one-hot grant.
// Purely combinational, zero latency; no backpressure, grant is all-zero when req is idle.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] gnt_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [N_REQ-1:0]   gnt_rot;
    logic               found;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N_REQ-1:0];
        gnt_rot = '0;
        found   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_rot[i] && !found) begin
                gnt_rot[i] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_dbl = {gnt_rot, gnt_rot} << ptr;
        grant   = gnt_dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/led_cmd_arbiter.sv
// Arbitrates N_REQ LED commands round-robin, drives led_code/led_lit, tracks a LEDOut shadow.
// led_code valid 1 cycle after req is sampled, ack 2+SETTLE cycles after; requesters hold req until ack.
module led_cmd_arbiter
    import led_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int SETTLE = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [LED_IDX_W*N_REQ-1:0] req_idx,
    input  logic [N_REQ-1:0]           req_lit,
    output logic [N_REQ-1:0]           ack,
    output logic                       busy,
    output logic [LED_W-1:0]           led_code,
    output logic                       led_lit,
    output logic [LED_W-1:0]           led_shadow
);

    localparam int PTR_W = $clog2(N_REQ);

    led_state_e       state, state_nx;
    logic [PTR_W-1:0] rr_ptr, ptr_nx;
    logic [3:0]       cnt, cnt_nx;
    logic [N_REQ-1:0] win_oh, win_nx;
    led_cmd_t         cmd, cmd_nx;
    logic [N_REQ-1:0] ack_nx;
    logic [LED_W-1:0] code_nx;
    logic             lit_nx;
    logic [LED_W-1:0] shadow_nx;

    logic [N_REQ-1:0] grant;
    led_cmd_t         sel_cmd;
    logic [PTR_W-1:0] win_idx;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        sel_cmd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_cmd.idx = req_idx[i*LED_IDX_W +: LED_IDX_W];
                sel_cmd.lit = req_lit[i];
            end
        end
    end

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        ptr_nx    = rr_ptr;
        cnt_nx    = cnt;
        win_nx    = win_oh;
        cmd_nx    = cmd;
        ack_nx    = '0;
        code_nx   = led_code;
        lit_nx    = led_lit;
        shadow_nx = led_shadow;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nx = GRANT;
                    win_nx   = grant;
                    cmd_nx   = sel_cmd;
                    code_nx  = {{(LED_W-LED_IDX_W){1'b0}}, sel_cmd.idx};
                    lit_nx   = sel_cmd.lit;
                end
            end
            GRANT: begin
                state_nx = HOLD;
                cnt_nx   = 4'd1;
            end
            HOLD: begin
                // Leaving HOLD commits the command: ack, shadow and pointer move together.
                if (cnt == 4'(SETTLE)) begin
                    state_nx  = ACK;
                    cnt_nx    = 4'd0;
                    ack_nx    = win_oh;
                    shadow_nx = shadow_apply(led_shadow, cmd);
                    ptr_nx    = (win_idx == PTR_W'(N_REQ-1)) ? '0 : win_idx + PTR_W'(1);
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            ACK: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            cnt        <= 4'd0;
            win_oh     <= '0;
            cmd        <= '0;
            ack        <= '0;
            busy       <= 1'b0;
            led_code   <= '0;
            led_lit    <= 1'b0;
            led_shadow <= '0;
        end else begin
            state      <= state_nx;
            rr_ptr     <= ptr_nx;
            cnt        <= cnt_nx;
            win_oh     <= win_nx;
            cmd        <= cmd_nx;
            ack        <= ack_nx;
            busy       <= (state_nx != IDLE);
            led_code   <= code_nx;
            led_lit    <= lit_nx;
            led_shadow <= shadow_nx;
        end
    end

endmodule
